addr_counter: RTL and testbench

ADDR_COUNTER -- requirements
Module: addr_counter

---
 rtl/i8080_pkg.sv | 20 ++
 rtl/addr_counter.sv | 152 +++++++++++++++
 tb/tb_addr_counter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i8080_pkg.sv
// Shared command and state encodings for the 8080 address counters (PC, SP)
// and the control unit that drives them.
package i8080_pkg;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_INC  = 3'd1,
        CMD_DEC  = 3'd2,
        CMD_SET  = 3'd3,
        CMD_LOAD = 3'd4,
        CMD_OUT  = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/addr_counter.sv
// Address counter with INC/DEC/SET and byte-serial LOAD/OUT over a DATA_W bus.
// Instantiated as both PC and SP; the command set used is up to the caller.
//
// state   | meaning
// ST_IDLE | ready for a command; INC/DEC/SET complete here in one cycle
// ST_LOAD | collecting bytes LSB first; idx_q == NBYTES is the done cycle
// ST_OUT  | presenting snapshot bytes LSB first on dat_o
module addr_counter
    import i8080_pkg::*;
#(
    parameter int              ADDR_W    = 16,
    parameter int              DATA_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
    input  logic              clk50M_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    input  logic [2:0]        cmd_i,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              dat_valid_i,
    output logic [DATA_W-1:0] dat_o,
    output logic              dat_oe_o,
    input  logic              dat_ready_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              done_o
);

    localparam int NBYTES = ADDR_W / DATA_W;
    localparam int IDX_W  = $clog2(NBYTES + 1);

    if (ADDR_W == 0 || (ADDR_W % DATA_W) != 0) begin : g_bad_width
        $error("addr_counter: ADDR_W must be a nonzero multiple of DATA_W");
    end

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]   dat_o_q, dat_o_d;
    logic                dat_oe_q, dat_oe_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   shift_in;
    cmd_e                cmd;

    assign cmd = cmd_e'(cmd_i);

    // Bytes enter at the top and move down, so after NBYTES beats byte 0 sits at the LSB.
    assign shift_in = (shadow_q >> DATA_W) | (ADDR_W'(dat_i) << (ADDR_W - DATA_W));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        shadow_d = shadow_q;
        dat_o_d  = '0;
        dat_oe_d = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    case (cmd)
                        CMD_INC: begin
                            addr_d = addr_q + ADDR_W'(1);
                            done_d = 1'b1;
                        end
                        CMD_DEC: begin
                            addr_d = addr_q - ADDR_W'(1);
                            done_d = 1'b1;
                        end
                        CMD_SET: begin
                            addr_d = addr_i;
                            done_d = 1'b1;
                        end
                        CMD_LOAD: begin
                            state_d  = ST_LOAD;
                            idx_d    = '0;
                            shadow_d = '0;
                        end
                        CMD_OUT: begin
                            state_d  = ST_OUT;
                            idx_d    = '0;
                            shadow_d = addr_q >> DATA_W;
                            dat_o_d  = addr_q[DATA_W-1:0];
                            dat_oe_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (idx_q == IDX_W'(NBYTES)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else if (dat_valid_i) begin
                    shadow_d = shift_in;
                    idx_d    = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NBYTES - 1)) begin
                        addr_d = shift_in;
                    end
                end
            end
            ST_OUT: begin
                dat_o_d  = dat_o_q;
                dat_oe_d = 1'b1;
                if (dat_ready_i) begin
                    if (idx_q == IDX_W'(NBYTES - 1)) begin
                        state_d  = ST_IDLE;
                        idx_d    = '0;
                        dat_o_d  = '0;
                        dat_oe_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        dat_o_d  = shadow_q[DATA_W-1:0];
                        shadow_d = shadow_q >> DATA_W;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk50M_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            addr_q   <= RESET_VAL;
            shadow_q <= '0;
            dat_o_q  <= '0;
            dat_oe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            shadow_q <= shadow_d;
            dat_o_q  <= dat_o_d;
            dat_oe_q <= dat_oe_d;
            done_q   <= done_d;
        end
    end

    assign ready_o  = (state_q == ST_IDLE);
    assign addr_o   = addr_q;
    assign dat_o    = dat_o_q;
    assign dat_oe_o = dat_oe_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_addr_counter.sv
// Scoreboard bench for addr_counter: directed scenarios plus random command mix
// on a 16/8 instance, and a 24/8 instance for three-byte OUT.
module tb_addr_counter;
    import i8080_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd = 3'd0;
    logic        ready;
    logic [15:0] addr_in = '0;
    logic [7:0]  dat_in = '0;
    logic        dat_valid = 1'b0;
    logic [7:0]  dat_out;
    logic        dat_oe;
    logic        dat_ready = 1'b0;
    logic [15:0] addr_out;
    logic        done;

    logic        cmd_valid2 = 1'b0;
    logic [2:0]  cmd2 = 3'd0;
    logic        ready2;
    logic [23:0] addr_in2 = '0;
    logic [7:0]  dat_in2 = '0;
    logic        dat_valid2 = 1'b0;
    logic [7:0]  dat_out2;
    logic        dat_oe2;
    logic        dat_ready2 = 1'b0;
    logic [23:0] addr_out2;
    logic        done2;

    addr_counter #(.ADDR_W(16), .DATA_W(8), .RESET_VAL(16'h0000)) dut (
        .clk50M_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_i(cmd),
        .ready_o(ready), .addr_i(addr_in), .dat_i(dat_in), .dat_valid_i(dat_valid),
        .dat_o(dat_out), .dat_oe_o(dat_oe), .dat_ready_i(dat_ready),
        .addr_o(addr_out), .done_o(done)
    );

    addr_counter #(.ADDR_W(24), .DATA_W(8), .RESET_VAL(24'h000000)) dut24 (
        .clk50M_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid2), .cmd_i(cmd2),
        .ready_o(ready2), .addr_i(addr_in2), .dat_i(dat_in2), .dat_valid_i(dat_valid2),
        .dat_o(dat_out2), .dat_oe_o(dat_oe2), .dat_ready_i(dat_ready2),
        .addr_o(addr_out2), .done_o(done2)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] exp_done_q[$];
    logic [7:0]  exp_byte_q[$];
    int          model_addr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse and every byte handed over must match the next expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (exp_done_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
                else chk("done_addr", 32'(addr_out), 32'(exp_done_q.pop_front()));
            end
            if (dat_oe && dat_ready) begin
                if (exp_byte_q.size() == 0) chk("byte_unexpected", 32'(dat_oe), 32'd0);
                else chk("out_byte", 32'(dat_out), 32'(exp_byte_q.pop_front()));
            end
            if (!dat_oe) chk("dat_o_idle_zero", 32'(dat_out), 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!ready && t < 50) begin
            cyc();
            t++;
        end
        chk("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic do_cmd(input logic [2:0] c, input logic [15:0] a);
        wait_ready();
        cmd_valid = 1'b1;
        cmd       = c;
        addr_in   = a;
        dat_valid = 1'($urandom_range(0, 1));
        dat_ready = 1'($urandom_range(0, 1));
        dat_in    = 8'($urandom);
        case (c)
            3'd1: begin model_addr = (model_addr + 1) % 65536; exp_done_q.push_back(16'(model_addr)); end
            3'd2: begin model_addr = (model_addr + 65535) % 65536; exp_done_q.push_back(16'(model_addr)); end
            3'd3: begin model_addr = int'(a); exp_done_q.push_back(a); end
            default: ;
        endcase
        cyc();
        cmd_valid = 1'b0;
        dat_valid = 1'b0;
        dat_ready = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] b0, input logic [7:0] b1, input int gap0, input int gap1);
        int gaps[2];
        logic [7:0] bytes[2];
        gaps[0] = gap0; gaps[1] = gap1;
        bytes[0] = b0;  bytes[1] = b1;
        wait_ready();
        cmd_valid = 1'b1;
        cmd       = 3'd4;
        cyc();
        for (int k = 0; k < 2; k++) begin
            for (int g = 0; g < gaps[k]; g++) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd       = 3'd1;
                dat_valid = 1'b0;
                dat_in    = 8'($urandom);
                chk("load_ready_low", 32'(ready), 32'd0);
                chk("load_addr_hold", 32'(addr_out), 32'(model_addr));
                cyc();
            end
            cmd_valid = 1'b0;
            chk("load_addr_hold", 32'(addr_out), 32'(model_addr));
            dat_valid = 1'b1;
            dat_in    = bytes[k];
            cyc();
            dat_valid = 1'b0;
        end
        model_addr = int'(b1) * 256 + int'(b0);
        exp_done_q.push_back(16'(model_addr));
        chk("load_commit_addr", 32'(addr_out), 32'(model_addr));
        chk("load_done_late", 32'(done), 32'd0);
        cyc();
    endtask

    task automatic do_out(input int stall0, input int stall1);
        int stalls[2];
        logic [7:0] b;
        stalls[0] = stall0; stalls[1] = stall1;
        wait_ready();
        cmd_valid = 1'b1;
        cmd       = 3'd5;
        for (int k = 0; k < 2; k++) exp_byte_q.push_back(8'((model_addr >> (8 * k)) % 256));
        exp_done_q.push_back(16'(model_addr));
        cyc();
        for (int k = 0; k < 2; k++) begin
            b = 8'((model_addr >> (8 * k)) % 256);
            for (int s = 0; s < stalls[k]; s++) begin
                cmd_valid = 1'b1;
                cmd       = 3'd1;
                dat_ready = 1'b0;
                chk("out_oe", 32'(dat_oe), 32'd1);
                chk("out_hold", 32'(dat_out), 32'(b));
                cyc();
            end
            cmd_valid = 1'b0;
            dat_ready = 1'b1;
            cyc();
            dat_ready = 1'b0;
        end
        chk("out_oe_drop", 32'(dat_oe), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        model_addr = 0;
        exp_done_q.delete();
        exp_byte_q.delete();
    endtask

    initial begin
        int op;
        logic [15:0] ra;
        do_reset();
        chk("rst_addr", 32'(addr_out), 32'h0000);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_oe", 32'(dat_oe), 32'd0);
        chk("rst_dat", 32'(dat_out), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);

        do_cmd(3'd3, 16'hFFFF);
        do_cmd(3'd1, 16'h0000);
        chk("inc_wrap", 32'(addr_out), 32'h0000);
        cyc();
        chk("inc_done_single", 32'(done), 32'd0);
        do_cmd(3'd2, 16'h0000);
        chk("dec_wrap", 32'(addr_out), 32'hFFFF);
        do_cmd(3'd3, 16'h1234);
        chk("set_addr", 32'(addr_out), 32'h1234);
        do_cmd(3'd3, 16'h5555);

        do_load(8'h34, 8'h12, 0, 3);
        chk("load_result", 32'(addr_out), 32'h1234);

        do_cmd(3'd3, 16'hBEEF);
        do_out(2, 0);
        chk("out_addr_kept", 32'(addr_out), 32'hBEEF);

        do_cmd(3'd0, 16'h0000);
        do_cmd(3'd6, 16'h0000);
        do_cmd(3'd7, 16'h0000);
        cyc();
        chk("nop_addr", 32'(addr_out), 32'hBEEF);

        // Reset in the middle of a LOAD must discard the captured byte.
        do_cmd(3'd3, 16'h7777);
        wait_ready();
        cmd_valid = 1'b1; cmd = 3'd4;
        cyc();
        cmd_valid = 1'b0; dat_valid = 1'b1; dat_in = 8'hAA;
        cyc();
        dat_valid = 1'b0;
        do_reset();
        chk("rst_abort_addr", 32'(addr_out), 32'h0000);
        chk("rst_abort_ready", 32'(ready), 32'd1);
        do_load(8'h11, 8'h22, 1, 0);
        chk("load_after_abort", 32'(addr_out), 32'h2211);

        for (int i = 0; i < 250; i++) begin
            op = $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0: ra = 16'h0000;
                1: ra = 16'hFFFF;
                default: ra = 16'($urandom);
            endcase
            case (op)
                0: do_cmd(3'd1, ra);
                1: do_cmd(3'd2, ra);
                2: do_cmd(3'd3, ra);
                3: do_cmd(3'($urandom_range(0, 7)) == 3'd0 ? 3'd0 : 3'($urandom_range(6, 7)), ra);
                4, 5: do_load(8'($urandom), 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
                default: do_out($urandom_range(0, 2), $urandom_range(0, 2));
            endcase
        end

        for (int t = 0; t < 20 && (exp_done_q.size() != 0 || exp_byte_q.size() != 0); t++) cyc();
        cyc();
        chk("drain_done", 32'(exp_done_q.size()), 32'd0);
        chk("drain_bytes", 32'(exp_byte_q.size()), 32'd0);
        chk("final_addr", 32'(addr_out), 32'(model_addr));

        // Three-byte instance: SET then OUT of 24'hABCDEF, INC ignored mid-OUT.
        cmd_valid2 = 1'b1; cmd2 = 3'd3; addr_in2 = 24'hABCDEF;
        cyc();
        chk("w24_set", 32'(addr_out2), 32'h00ABCDEF);
        chk("w24_set_done", 32'(done2), 32'd1);
        cmd2 = 3'd5;
        cyc();
        chk("w24_oe", 32'(dat_oe2), 32'd1);
        chk("w24_b0", 32'(dat_out2), 32'h000000EF);
        chk("w24_ready_low", 32'(ready2), 32'd0);
        cmd2 = 3'd1;
        cyc();
        cmd_valid2 = 1'b0;
        chk("w24_b0_hold", 32'(dat_out2), 32'h000000EF);
        dat_ready2 = 1'b1;
        cyc();
        chk("w24_b1", 32'(dat_out2), 32'h000000CD);
        cyc();
        chk("w24_b2", 32'(dat_out2), 32'h000000AB);
        chk("w24_no_early_done", 32'(done2), 32'd0);
        cyc();
        dat_ready2 = 1'b0;
        chk("w24_oe_drop", 32'(dat_oe2), 32'd0);
        chk("w24_done", 32'(done2), 32'd1);
        chk("w24_dat_zero", 32'(dat_out2), 32'd0);
        chk("w24_addr_kept", 32'(addr_out2), 32'h00ABCDEF);
        cyc();
        chk("w24_done_single", 32'(done2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
